// File: rtl/pipe_trace_buffer.sv
// -----------------------------------------------------------------------------
// pipe_trace_buffer
//
// On-chip pipeline trace capture for RISCVCPU. Each accepted cycle snapshot
// (IF PC, IF/ID instruction, per-stage valid bits, cycle stamp, trigger flag)
// is written into a circular buffer. After a trigger, a programmable number
// of further samples is captured. Capture then freezes and the window is
// streamed out oldest-first over a valid/ready port.
//
// Optional build macro:
//   TRACE_NOP_FILTER_EN - when defined, samples whose instruction is the
//                         canonical NOP (32'h00000013) are dropped. A NOP
//                         that arrives together with the trigger pulse is
//                         still stored as the trigger sample. Dropped samples
//                         do not count toward POST_TRIG.
//
// Ports:
//   clock, reset_n      - system clock, asynchronous active-low reset
//   en                  - arm request (level)
//   trig                - trigger pulse
//   sample_valid        - snapshot on sample_* is valid this cycle
//   sample_pc/ir        - IF-stage PC, IF/ID instruction word
//   sample_stage_valid  - per-stage valid bits
//   rd_valid/rd_ready   - readout handshake
//   rd_pc/ir/stage_valid/cycle/trig/last - registered readout entry
//   state               - 0 IDLE, 1 ARMED, 2 POST, 3 DUMP
//   cycle_count         - free-running cycle counter
// -----------------------------------------------------------------------------
module pipe_trace_buffer #(
   parameter int XLEN      = 32,
   parameter int DEPTH     = 16,
   parameter int STAGES    = 5,
   parameter int CNT_W     = 64,
   parameter int POST_TRIG = 8
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              en,
   input  logic              trig,
   input  logic              sample_valid,
   input  logic [XLEN-1:0]   sample_pc,
   input  logic [XLEN-1:0]   sample_ir,
   input  logic [STAGES-1:0] sample_stage_valid,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [XLEN-1:0]   rd_pc,
   output logic [XLEN-1:0]   rd_ir,
   output logic [STAGES-1:0] rd_stage_valid,
   output logic [CNT_W-1:0]  rd_cycle,
   output logic              rd_trig,
   output logic              rd_last,
   output logic [1:0]        state,
   output logic [CNT_W-1:0]  cycle_count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W:0]   FULL        = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   ONE         = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] POST_TARGET = PTR_W'(POST_TRIG);
`ifdef TRACE_NOP_FILTER_EN
   localparam logic [XLEN-1:0]  NOP_IR      = XLEN'(32'h0000_0013);
`endif

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      POST  = 2'd2,
      DUMP  = 2'd3
   } state_t;

   typedef struct packed {
      logic [XLEN-1:0]   pc;
      logic [XLEN-1:0]   ir;
      logic [STAGES-1:0] stage_valid;
      logic [CNT_W-1:0]  cycle;
      logic              is_trig;
   } entry_t;

   state_t           state_q;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   fill;       // valid entries, saturates at DEPTH
   logic [PTR_W:0]   rd_left;    // entries still to follow the one on rd_*
   logic [PTR_W-1:0] post_cnt;
   logic             trig_stored;

   entry_t           mem [DEPTH];
   entry_t           wr_entry;
   entry_t           rd_src;
   entry_t           rd_q;

   logic             keep;
   logic             trig_here;
   logic             post_done;
   logic             accept;
   logic [PTR_W-1:0] rd_start;
   logic [PTR_W-1:0] rd_next;

   // Oldest valid entry; fill==DEPTH wraps to the write pointer itself.
   assign rd_start  = wr_ptr - fill[PTR_W-1:0];
   assign rd_next   = rd_ptr + 1'b1;
   // Capture window is closed once the trigger is in and enough followers
   // have been stored; the FSM leaves POST on the next edge.
   assign post_done = trig_stored && (post_cnt == POST_TARGET);

   // NOTE: every variable driven here gets a default first so no latch is inferred.
   always_comb begin
      keep      = 1'b1;
`ifdef TRACE_NOP_FILTER_EN
      keep      = (sample_ir != NOP_IR);
`endif
      trig_here = (state_q == ARMED) && trig;
      accept    = 1'b0;
      if (sample_valid && (keep || trig_here)) begin
         if (state_q == ARMED)
            accept = 1'b1;
         else if ((state_q == POST) && !post_done)
            accept = 1'b1;
      end

      wr_entry.pc          = sample_pc;
      wr_entry.ir          = sample_ir;
      wr_entry.stage_valid = sample_stage_valid;
      wr_entry.cycle       = cycle_count;
      // Trigger flag: either stored alongside the pulse, or the first
      // sample accepted after a pulse that came without one.
      wr_entry.is_trig     = trig_here || ((state_q == POST) && !trig_stored);

      // First entry when entering DUMP, next entry on each handshake.
      rd_src = (state_q == DUMP) ? mem[rd_next] : mem[rd_start];
   end

   // NOTE: trace storage is deliberately left out of reset; the fill count
   // alone decides which entries are meaningful.
   always_ff @(posedge clock) begin
      if (accept)
         mem[wr_ptr] <= wr_entry;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // right-hand side sees pre-edge values regardless of statement order.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         cycle_count <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         fill        <= '0;
         rd_left     <= '0;
         post_cnt    <= '0;
         trig_stored <= 1'b0;
         rd_valid    <= 1'b0;
         rd_last     <= 1'b0;
         rd_q        <= '0;
      end else begin
         cycle_count <= cycle_count + 1'b1;

         if (accept) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (fill != FULL)
               fill <= fill + 1'b1;
         end

         unique case (state_q)
            IDLE: begin
               if (en) begin
                  state_q     <= ARMED;
                  wr_ptr      <= '0;
                  fill        <= '0;
                  post_cnt    <= '0;
                  trig_stored <= 1'b0;
               end
            end

            ARMED: begin
               if (!en) begin
                  state_q <= IDLE;
               end else if (trig) begin
                  state_q     <= POST;
                  trig_stored <= sample_valid;
                  post_cnt    <= '0;
               end
            end

            POST: begin
               if (!en) begin
                  state_q <= IDLE;
               end else if (post_done) begin
                  state_q  <= DUMP;
                  rd_ptr   <= rd_start;
                  rd_left  <= fill - 1'b1;
                  rd_last  <= (fill == ONE);
                  rd_valid <= 1'b1;
                  rd_q     <= rd_src;
               end else if (accept) begin
                  if (trig_stored)
                     post_cnt <= post_cnt + 1'b1;
                  else
                     trig_stored <= 1'b1;
               end
            end

            DUMP: begin
               if (rd_valid && rd_ready) begin
                  if (rd_last) begin
                     state_q  <= IDLE;
                     rd_valid <= 1'b0;
                     rd_last  <= 1'b0;
                  end else begin
                     rd_ptr  <= rd_next;
                     rd_left <= rd_left - 1'b1;
                     rd_last <= (rd_left == ONE);
                     rd_q    <= rd_src;
                  end
               end
            end

            default: state_q <= IDLE;
         endcase
      end
   end

   assign state          = state_q;
   assign rd_pc          = rd_q.pc;
   assign rd_ir          = rd_q.ir;
   assign rd_stage_valid = rd_q.stage_valid;
   assign rd_cycle       = rd_q.cycle;
   assign rd_trig        = rd_q.is_trig;

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// -----------------------------------------------------------------------------
// tb_pipe_trace_buffer
//
// Drives pipe_trace_buffer (DEPTH=8, POST_TRIG=3) through directed scenarios
// and a randomized phase. A queue-based reference model tracks the capture
// window; every cycle the DUT state, counter and readout are compared to it.
// -----------------------------------------------------------------------------
module tb_pipe_trace_buffer;

   localparam int XLEN      = 32;
   localparam int DEPTH     = 8;
   localparam int STAGES    = 5;
   localparam int CNT_W     = 64;
   localparam int POST_TRIG = 3;
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] ADD = 32'h0010_80b3;

   logic              clock = 1'b0;
   logic              reset_n;
   logic              en;
   logic              trig;
   logic              sample_valid;
   logic [XLEN-1:0]   sample_pc;
   logic [XLEN-1:0]   sample_ir;
   logic [STAGES-1:0] sample_stage_valid;
   logic              rd_valid;
   logic              rd_ready;
   logic [XLEN-1:0]   rd_pc;
   logic [XLEN-1:0]   rd_ir;
   logic [STAGES-1:0] rd_stage_valid;
   logic [CNT_W-1:0]  rd_cycle;
   logic              rd_trig;
   logic              rd_last;
   logic [1:0]        state;
   logic [CNT_W-1:0]  cycle_count;

   pipe_trace_buffer #(
      .XLEN(XLEN), .DEPTH(DEPTH), .STAGES(STAGES), .CNT_W(CNT_W), .POST_TRIG(POST_TRIG)
   ) dut (
      .clock(clock), .reset_n(reset_n), .en(en), .trig(trig),
      .sample_valid(sample_valid), .sample_pc(sample_pc), .sample_ir(sample_ir),
      .sample_stage_valid(sample_stage_valid),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_pc(rd_pc), .rd_ir(rd_ir),
      .rd_stage_valid(rd_stage_valid), .rd_cycle(rd_cycle), .rd_trig(rd_trig),
      .rd_last(rd_last), .state(state), .cycle_count(cycle_count)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ir;
      logic [4:0]  sv;
      logic [63:0] cyc;
      logic        trig;
      logic        last;
   } ent_t;

   // Reference model: window contents as a queue plus phase bookkeeping.
   ent_t        q[$];
   ent_t        got[$];
   int          m_phase;
   int          m_post;
   int          m_rd;
   bit          m_trig_done;
   logic [63:0] m_cyc;

   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit keep_ir(input logic [31:0] ir);
`ifdef TRACE_NOP_FILTER_EN
      return ir != NOP;
`else
      return (ir == ir);
`endif
   endfunction

   task automatic model_reset();
      m_phase = 0; m_cyc = '0; m_rd = 0; m_post = 0; m_trig_done = 0;
      q.delete();
   endtask

   task automatic push(input logic t);
      q.push_back('{sample_pc, sample_ir, sample_stage_valid, m_cyc, t, 1'b0});
      if (q.size() > DEPTH) void'(q.pop_front());
   endtask

   task automatic model_step();
      case (m_phase)
         0: if (en) begin
               m_phase = 1; q.delete(); m_trig_done = 0; m_post = 0;
            end
         1: if (!en) m_phase = 0;
            else if (trig) begin
               m_phase = 2;
               m_trig_done = sample_valid;
               if (sample_valid) push(1'b1);
            end else if (sample_valid && keep_ir(sample_ir)) push(1'b0);
         2: if (!en) m_phase = 0;
            else if (m_trig_done && m_post == POST_TRIG) begin
               m_phase = 3; m_rd = 0;
            end else if (sample_valid && keep_ir(sample_ir)) begin
               if (!m_trig_done) begin push(1'b1); m_trig_done = 1; end
               else begin push(1'b0); m_post++; end
            end
         default: if (rd_ready) begin
               m_rd++;
               if (m_rd == q.size()) m_phase = 0;
            end
      endcase
      m_cyc++;
   endtask

   task automatic compare();
      check("state", 64'(state), 64'(m_phase));
      check("cycle_count", cycle_count, m_cyc);
      check("rd_valid", 64'(rd_valid), 64'(m_phase == 3));
      if (m_phase == 3 && m_rd < q.size()) begin
         check("rd_pc", 64'(rd_pc), 64'(q[m_rd].pc));
         check("rd_ir", 64'(rd_ir), 64'(q[m_rd].ir));
         check("rd_stage_valid", 64'(rd_stage_valid), 64'(q[m_rd].sv));
         check("rd_cycle", rd_cycle, q[m_rd].cyc);
         check("rd_trig", 64'(rd_trig), 64'(q[m_rd].trig));
         check("rd_last", 64'(rd_last), 64'(m_rd == q.size() - 1));
      end
   endtask

   // One clock: record any handshake, advance the model, sample at negedge.
   task automatic cycle();
      if (rd_valid && rd_ready)
         got.push_back('{rd_pc, rd_ir, rd_stage_valid, rd_cycle, rd_trig, rd_last});
      model_step();
      @(posedge clock);
      @(negedge clock);
      compare();
   endtask

   task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] ir, input bit t);
      sample_valid = v; sample_pc = pc; sample_ir = ir; trig = t;
      sample_stage_valid = 5'($urandom_range(0, 31));
      cycle();
   endtask

   // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random
   task automatic drain(input int mode);
      int n = 0;
      got.delete();
      en = 1'b0; trig = 1'b0; sample_valid = 1'b0;
      while (m_phase == 3 && n < 200) begin
         case (mode)
            0:       rd_ready = 1'b1;
            1:       rd_ready = ((n % 4) == 0) || ((n % 4) == 3);
            default: rd_ready = 1'($urandom_range(0, 1));
         endcase
         cycle();
         n++;
      end
      rd_ready = 1'b0;
      check("drain_idle", 64'(state), 64'd0);
   endtask

   initial begin
      reset_n = 1'b1; en = 1'b0; trig = 1'b0; sample_valid = 1'b0;
      sample_pc = '0; sample_ir = '0; sample_stage_valid = '0; rd_ready = 1'b0;

      // Asynchronous reset before any clock edge.
      #1 reset_n = 1'b0;
      #1;
      check("reset_state", 64'(state), 64'd0);
      check("reset_cycle_count", cycle_count, 64'd0);
      check("reset_rd_valid", 64'(rd_valid), 64'd0);
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      model_reset();
      for (int i = 0; i < 5; i++) cycle();
      check("cycle_count_after_5", cycle_count, 64'd5);

      // Wrap-around window: 20 samples, trigger on k=10.
      en = 1'b1;
      drive(1'b0, '0, '0, 1'b0);
      for (int k = 0; k < 20; k++) drive(1'b1, 32'(4 * k), 32'h1000_0000 | 32'(k), k == 10);
      drain(0);
      check("wrap_count", 64'(got.size()), 64'd8);
      for (int i = 0; i < got.size(); i++) begin
         check("wrap_pc", 64'(got[i].pc), 64'(24 + 4 * i));
         check("wrap_trig", 64'(got[i].trig), 64'(got[i].pc == 32'd40));
         check("wrap_last", 64'(got[i].last), 64'(i == 7));
         if (i > 0) check("wrap_stamp_inc", 64'(got[i].cyc > got[i-1].cyc), 64'd1);
      end

      // Partial fill with backpressure 1,0,0,1.
      en = 1'b1;
      drive(1'b0, '0, '0, 1'b0);
      for (int k = 0; k < 8; k++) drive(1'b1, 32'h100 + 32'(4 * k), ADD, k == 2);
      drain(1);
      check("partial_count", 64'(got.size()), 64'd6);
      for (int i = 0; i < got.size(); i++) begin
         check("partial_pc", 64'(got[i].pc), 64'(32'h100 + 32'(4 * i)));
         check("partial_trig", 64'(got[i].trig), 64'(i == 2));
         check("partial_last", 64'(got[i].last), 64'(i == 5));
      end

      // Abort in POST after one post sample, then re-arm.
      en = 1'b1;
      drive(1'b0, '0, '0, 1'b0);
      for (int k = 0; k < 4; k++) drive(1'b1, 32'h300 + 32'(4 * k), ADD, k == 2);
      en = 1'b0;
      drive(1'b0, '0, '0, 1'b0);
      check("abort_state", 64'(state), 64'd0);
      for (int i = 0; i < 3; i++) drive(1'b1, 32'h3f0, ADD, 1'b0);
      check("abort_no_valid", 64'(rd_valid), 64'd0);
      en = 1'b1;
      drive(1'b0, '0, '0, 1'b0);
      for (int k = 0; k < 6; k++) drive(1'b1, 32'h400 + 32'(4 * k), ADD, k == 0);
      drain(0);
      check("rearm_count", 64'(got.size()), 64'd4);
      if (got.size() > 0) check("rearm_first_pc", 64'(got[0].pc), 64'h400);

      // NOP stream with the trigger on a NOP.
      en = 1'b1;
      drive(1'b0, '0, '0, 1'b0);
      for (int k = 0; k < 12; k++)
         drive(1'b1, 32'h200 + 32'(4 * k), (k % 2 == 0) ? NOP : ADD, k == 4);
      drain(2);
      begin
`ifdef TRACE_NOP_FILTER_EN
         int exp_n = 6; int trig_idx = 2;
`else
         int exp_n = 8; int trig_idx = 4;
`endif
         check("nop_count", 64'(got.size()), 64'(exp_n));
         for (int i = 0; i < got.size(); i++) begin
            check("nop_trig_pos", 64'(got[i].trig), 64'(i == trig_idx));
`ifdef TRACE_NOP_FILTER_EN
            check("nop_only_trig", 64'(got[i].ir == NOP), 64'(got[i].trig));
`endif
         end
         if (got.size() > trig_idx) check("nop_trig_ir", 64'(got[trig_idx].ir), 64'(NOP));
      end

      // Reset asserted mid-dump, between clock edges.
      en = 1'b1;
      drive(1'b0, '0, '0, 1'b0);
      for (int k = 0; k < 6; k++) drive(1'b1, 32'h500 + 32'(4 * k), ADD, k == 0);
      en = 1'b0;
      drive(1'b0, '0, '0, 1'b0);
      check("pre_reset_dump", 64'(state), 64'd3);
      #2 reset_n = 1'b0;
      #1;
      check("midreset_state", 64'(state), 64'd0);
      check("midreset_rd_valid", 64'(rd_valid), 64'd0);
      check("midreset_cycle_count", cycle_count, 64'd0);
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      model_reset();

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         en       = ($urandom_range(0, 99) < 98);
         rd_ready = 1'($urandom_range(0, 1));
         drive(($urandom_range(0, 3) != 0), $urandom(),
               ($urandom_range(0, 3) == 0) ? NOP : $urandom(),
               ($urandom_range(0, 99) < 8));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
